// File: rtl/trigger_capture_if.sv
`default_nettype none
// ============================================================================
// trigger_capture_if : ADC sample stream (12-bit data + one-cycle valid strobe)
// Rev 1.0
// ============================================================================
interface trigger_capture_if #(
   parameter int DW = 12
);
   logic [DW-1:0] sample_data;
   logic          sample_valid;

   modport master (output sample_data, output sample_valid);
   modport slave  (input  sample_data, input  sample_valid);
endinterface
`default_nettype wire

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// trigger_capture : decimating level/edge trigger with pre-trigger ring buffer,
// publishing one frame into data_display during vertical blank.  Rev 1.0
// ============================================================================
module trigger_capture #(
   parameter int DEPTH        = 256,
   parameter int PRETRIG      = 64,
   parameter int AUTO_TIMEOUT = 4096
) (
   input  wire                clk_i,
   input  wire                rst_ni,
   trigger_capture_if.slave   smp,
   input  wire [11:0]         trig_level_i,
   input  wire                trig_edge_i,
   input  wire                trig_auto_i,
   input  wire [3:0]          decim_i,
   input  wire                hold_i,
   input  wire                vblnk_i,
   output logic [11:0]        data_display_o [0:DEPTH-1],
   output logic               frame_done_o,
   output logic               triggered_o,
   output logic               busy_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(AUTO_TIMEOUT);
   localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
   localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRETRIG - 2);
   localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);
   localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
   localparam logic [TW-1:0] TOUT_LAST = TW'(AUTO_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_WAITV = 3'd4,
      ST_COPY  = 3'd5
   } state_e;

   state_e        state_q;
   logic [11:0]   cap_q  [0:DEPTH-1];
   logic [11:0]   disp_q [0:DEPTH-1];
   logic [AW-1:0] wp_q;
   logic [AW-1:0] fill_q;
   logic [AW-1:0] tp_q;
   logic [AW-1:0] cidx_q;
   logic [3:0]    dcnt_q;
   logic [TW-1:0] tout_q;
   logic [11:0]   prev_q;
   logic          prev_valid_q;
   logic          trig_nxt_q;
   logic          vblnk_q;
   logic          frame_done_q;
   logic          triggered_q;

   logic          capturing;
   logic          accept;
   logic          trig_hit;
   logic          vblnk_rise;
   logic [AW-1:0] rd_addr;

   assign capturing  = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
   assign accept     = capturing && smp.sample_valid && (dcnt_q == decim_i);
   assign vblnk_rise = vblnk_i && !vblnk_q;
   // Frame starts PRETRIG entries before the trigger address; 8-bit wrap is intended.
   assign rd_addr    = tp_q - PRE_OFS + cidx_q;

   always_comb begin
      trig_hit = 1'b0;
      if (prev_valid_q) begin
         if (trig_edge_i)
            trig_hit = (prev_q > trig_level_i) && (smp.sample_data <= trig_level_i);
         else
            trig_hit = (prev_q < trig_level_i) && (smp.sample_data >= trig_level_i);
      end
   end

   // Capture ring buffer carries no reset so it can map onto block RAM.
   always_ff @(posedge clk_i) begin
      if (accept)
         cap_q[wp_q] <= smp.sample_data;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         wp_q         <= '0;
         fill_q       <= '0;
         tp_q         <= '0;
         cidx_q       <= '0;
         dcnt_q       <= '0;
         tout_q       <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         trig_nxt_q   <= 1'b0;
         vblnk_q      <= 1'b0;
         frame_done_q <= 1'b0;
         triggered_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            disp_q[i] <= '0;
      end else begin
         frame_done_q <= 1'b0;
         vblnk_q      <= vblnk_i;

         if (capturing && smp.sample_valid)
            dcnt_q <= (dcnt_q == decim_i) ? 4'd0 : dcnt_q + 4'd1;

         if (accept) begin
            wp_q         <= wp_q + AW'(1);
            prev_q       <= smp.sample_data;
            prev_valid_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               fill_q       <= '0;
               prev_valid_q <= 1'b0;
               state_q      <= ST_PRE;
            end
            ST_PRE: begin
               if (accept) begin
                  if (fill_q == PRE_LAST) begin
                     fill_q  <= '0;
                     tout_q  <= '0;
                     state_q <= ST_ARMED;
                  end else begin
                     fill_q <= fill_q + AW'(1);
                  end
               end
            end
            ST_ARMED: begin
               // A real trigger takes priority over the auto timeout.
               if (accept) begin
                  if (trig_hit) begin
                     tp_q       <= wp_q;
                     trig_nxt_q <= 1'b1;
                     fill_q     <= '0;
                     state_q    <= ST_POST;
                  end else if (trig_auto_i && (tout_q == TOUT_LAST)) begin
                     tp_q       <= wp_q;
                     trig_nxt_q <= 1'b0;
                     fill_q     <= '0;
                     state_q    <= ST_POST;
                  end else begin
                     tout_q <= tout_q + TW'(1);
                  end
               end
            end
            ST_POST: begin
               if (accept) begin
                  if (fill_q == POST_LAST)
                     state_q <= ST_WAITV;
                  else
                     fill_q <= fill_q + AW'(1);
               end
            end
            ST_WAITV: begin
               if (vblnk_rise && !hold_i) begin
                  cidx_q  <= '0;
                  state_q <= ST_COPY;
               end
            end
            ST_COPY: begin
               disp_q[cidx_q] <= cap_q[rd_addr];
               cidx_q         <= cidx_q + AW'(1);
               if (cidx_q == LAST_IDX) begin
                  triggered_q  <= trig_nxt_q;
                  frame_done_q <= 1'b1;
                  fill_q       <= '0;
                  prev_valid_q <= 1'b0;
                  state_q      <= ST_PRE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_display_o = disp_q;
   assign frame_done_o   = frame_done_q;
   assign triggered_o    = triggered_q;
   assign busy_o         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// tb_trigger_capture : directed scenarios with hand-computed frame contents.
// Rev 1.0
// ============================================================================
module tb_trigger_capture;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic [11:0] trig_level = 12'd2048;
   logic        trig_edge  = 1'b0;
   logic        trig_auto  = 1'b0;
   logic [3:0]  decim      = 4'd0;
   logic        hold       = 1'b0;
   logic        vblnk      = 1'b0;
   logic [11:0] disp [0:255];
   logic        frame_done;
   logic        triggered;
   logic        busy;

   int checks = 0;
   int passed = 0;
   int fd_cnt = 0;

   trigger_capture_if #(.DW(12)) smp_if ();

   trigger_capture dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .smp            (smp_if.slave),
      .trig_level_i   (trig_level),
      .trig_edge_i    (trig_edge),
      .trig_auto_i    (trig_auto),
      .decim_i        (decim),
      .hold_i         (hold),
      .vblnk_i        (vblnk),
      .data_display_o (disp),
      .frame_done_o   (frame_done),
      .triggered_o    (triggered),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done) fd_cnt++;

   task automatic stream_ramp(input int n, input int start, input int step);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         smp_if.sample_valid = 1'b1;
         smp_if.sample_data  = 12'((start + step * k) % 4096);
      end
      @(negedge clk);
      smp_if.sample_valid = 1'b0;
   endtask

   task automatic pulse_vblnk();
      @(negedge clk) vblnk = 1'b1;
      repeat (2) @(negedge clk);
      vblnk = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_frame(input int f0, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (fd_cnt != f0) break;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (disp[0] !== 12'd0) $display("FAIL rst_disp0 got %0d exp 0", disp[0]); else passed++;
      checks++; if (disp[255] !== 12'd0) $display("FAIL rst_disp255 got %0d exp 0", disp[255]); else passed++;
      checks++; if (triggered !== 1'b0) $display("FAIL rst_triggered got %0b exp 0", triggered); else passed++;
      checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done got %0b exp 0", frame_done); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else passed++;
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b1) $display("FAIL rst_busy_after got %0b exp 1", busy); else passed++;
   endtask

   task automatic test_ramp();
      int f0;
      trig_level = 12'd2048; trig_edge = 1'b0; trig_auto = 1'b0; decim = 4'd0; hold = 1'b0;
      f0 = fd_cnt;
      stream_ramp(320, 0, 16);
      pulse_vblnk();
      wait_frame(f0, 600);
      repeat (20) @(negedge clk);
      checks++; if (fd_cnt - f0 !== 1) $display("FAIL ramp_done_count got %0d exp 1", fd_cnt - f0); else passed++;
      checks++; if (disp[0] !== 12'd1024) $display("FAIL ramp_d0 got %0d exp 1024", disp[0]); else passed++;
      checks++; if (disp[63] !== 12'd2032) $display("FAIL ramp_d63 got %0d exp 2032", disp[63]); else passed++;
      checks++; if (disp[64] !== 12'd2048) $display("FAIL ramp_d64 got %0d exp 2048", disp[64]); else passed++;
      checks++; if (disp[255] !== 12'd1008) $display("FAIL ramp_d255 got %0d exp 1008", disp[255]); else passed++;
      checks++; if (triggered !== 1'b1) $display("FAIL ramp_triggered got %0b exp 1", triggered); else passed++;
   endtask

   task automatic test_auto();
      int f0;
      int bad;
      trig_level = 12'd2048; trig_auto = 1'b1;
      f0 = fd_cnt;
      stream_ramp(4350, 100, 0);
      pulse_vblnk();
      repeat (300) @(negedge clk);
      checks++; if (fd_cnt !== f0) $display("FAIL auto_early got %0d frames exp 0", fd_cnt - f0); else passed++;
      stream_ramp(1, 100, 0);
      pulse_vblnk();
      wait_frame(f0, 600);
      checks++; if (fd_cnt - f0 !== 1) $display("FAIL auto_done_count got %0d exp 1", fd_cnt - f0); else passed++;
      bad = 0;
      for (int i = 0; i < 256; i++) if (disp[i] !== 12'd100) bad++;
      checks++; if (bad !== 0) $display("FAIL auto_entries got %0d entries not 100 exp 0", bad); else passed++;
      checks++; if (triggered !== 1'b0) $display("FAIL auto_triggered got %0b exp 0", triggered); else passed++;
   endtask

   task automatic test_normal();
      int f0;
      trig_auto = 1'b0;
      f0 = fd_cnt;
      stream_ramp(20000, 100, 0);
      pulse_vblnk();
      repeat (300) @(negedge clk);
      checks++; if (fd_cnt !== f0) $display("FAIL normal_no_frame got %0d frames exp 0", fd_cnt - f0); else passed++;
      checks++; if (busy !== 1'b1) $display("FAIL normal_busy got %0b exp 1", busy); else passed++;
   endtask

   task automatic test_falling();
      int f0;
      trig_edge = 1'b1; trig_level = 12'd2000;
      f0 = fd_cnt;
      stream_ramp(2, 3000, 0);
      stream_ramp(1, 1000, 0);
      stream_ramp(191, 500, 0);
      pulse_vblnk();
      wait_frame(f0, 600);
      checks++; if (fd_cnt - f0 !== 1) $display("FAIL fall_done_count got %0d exp 1", fd_cnt - f0); else passed++;
      checks++; if (disp[64] !== 12'd1000) $display("FAIL fall_d64 got %0d exp 1000", disp[64]); else passed++;
      checks++; if (disp[63] !== 12'd3000) $display("FAIL fall_d63 got %0d exp 3000", disp[63]); else passed++;
      checks++; if (disp[62] !== 12'd3000) $display("FAIL fall_d62 got %0d exp 3000", disp[62]); else passed++;
      checks++; if (disp[61] !== 12'd100) $display("FAIL fall_d61 got %0d exp 100", disp[61]); else passed++;
      checks++; if (disp[255] !== 12'd500) $display("FAIL fall_d255 got %0d exp 500", disp[255]); else passed++;
      checks++; if (triggered !== 1'b1) $display("FAIL fall_triggered got %0b exp 1", triggered); else passed++;
   endtask

   task automatic test_decim();
      int f0;
      int bad;
      trig_edge = 1'b0; trig_level = 12'd2048; decim = 4'd3;
      f0 = fd_cnt;
      stream_ramp(2816, 0, 1);
      pulse_vblnk();
      wait_frame(f0, 600);
      checks++; if (fd_cnt - f0 !== 1) $display("FAIL decim_done_count got %0d exp 1", fd_cnt - f0); else passed++;
      checks++; if (disp[64] !== 12'd2051) $display("FAIL decim_d64 got %0d exp 2051", disp[64]); else passed++;
      checks++; if (disp[0] !== 12'd1795) $display("FAIL decim_d0 got %0d exp 1795", disp[0]); else passed++;
      checks++; if (disp[255] !== 12'd2815) $display("FAIL decim_d255 got %0d exp 2815", disp[255]); else passed++;
      bad = 0;
      for (int i = 0; i < 255; i++) if (int'(disp[i+1]) - int'(disp[i]) != 4) bad++;
      checks++; if (bad !== 0) $display("FAIL decim_step got %0d steps not 4 exp 0", bad); else passed++;
      decim = 4'd0;
   endtask

   task automatic test_hold();
      int f0;
      hold = 1'b1;
      f0 = fd_cnt;
      stream_ramp(320, 0, 16);
      repeat (3) pulse_vblnk();
      repeat (20) @(negedge clk);
      checks++; if (fd_cnt !== f0) $display("FAIL hold_no_frame got %0d frames exp 0", fd_cnt - f0); else passed++;
      checks++; if (disp[64] !== 12'd2051) $display("FAIL hold_unchanged got %0d exp 2051", disp[64]); else passed++;
      hold = 1'b0;
      @(negedge clk) vblnk = 1'b1;
      @(negedge clk) vblnk = 1'b0;
      repeat (10) @(negedge clk);
      hold = 1'b1;
      wait_frame(f0, 600);
      hold = 1'b0;
      checks++; if (fd_cnt - f0 !== 1) $display("FAIL hold_done_count got %0d exp 1", fd_cnt - f0); else passed++;
      checks++; if (disp[0] !== 12'd1024) $display("FAIL hold_d0 got %0d exp 1024", disp[0]); else passed++;
      checks++; if (disp[64] !== 12'd2048) $display("FAIL hold_d64 got %0d exp 2048", disp[64]); else passed++;
      checks++; if (disp[255] !== 12'd1008) $display("FAIL hold_d255 got %0d exp 1008", disp[255]); else passed++;
   endtask

   task automatic test_reset_copy();
      int f0;
      int bad;
      stream_ramp(320, 8, 16);
      @(negedge clk) vblnk = 1'b1;
      @(posedge clk);
      #1 vblnk = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      checks++; if (disp[0] !== 12'd1032) $display("FAIL mid_d0 got %0d exp 1032", disp[0]); else passed++;
      checks++; if (disp[99] !== 12'd2616) $display("FAIL mid_d99 got %0d exp 2616", disp[99]); else passed++;
      checks++; if (disp[100] !== 12'd2624) $display("FAIL mid_d100_old got %0d exp 2624", disp[100]); else passed++;
      rst_n = 1'b0;
      #1;
      bad = 0;
      for (int i = 0; i < 256; i++) if (disp[i] !== 12'd0) bad++;
      checks++; if (bad !== 0) $display("FAIL rstcopy_clear got %0d nonzero exp 0", bad); else passed++;
      checks++; if (triggered !== 1'b0) $display("FAIL rstcopy_triggered got %0b exp 0", triggered); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rstcopy_busy got %0b exp 0", busy); else passed++;
      checks++; if (frame_done !== 1'b0) $display("FAIL rstcopy_done got %0b exp 0", frame_done); else passed++;
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      f0 = fd_cnt;
      stream_ramp(320, 8, 16);
      pulse_vblnk();
      wait_frame(f0, 600);
      checks++; if (fd_cnt - f0 !== 1) $display("FAIL after_done_count got %0d exp 1", fd_cnt - f0); else passed++;
      bad = 0;
      for (int i = 0; i < 256; i++) if (disp[i] !== 12'((8 + 16 * (64 + i)) % 4096)) bad++;
      checks++; if (bad !== 0) $display("FAIL after_frame got %0d wrong entries exp 0", bad); else passed++;
      checks++; if (disp[64] !== 12'd2056) $display("FAIL after_d64 got %0d exp 2056", disp[64]); else passed++;
      checks++; if (triggered !== 1'b1) $display("FAIL after_triggered got %0b exp 1", triggered); else passed++;
   endtask

   initial begin
      smp_if.sample_valid = 1'b0;
      smp_if.sample_data  = 12'd0;
      test_reset();
      test_ramp();
      test_auto();
      test_normal();
      test_falling();
      test_decim();
      test_hold();
      test_reset_copy();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
